// File: rtl/aes_ctrl_pkg.sv
// Shared AES round-sequencer definitions: FSM state encoding, key-length codes and round counts.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADD    = 3'd1,
        ST_SUB    = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_MIX    = 3'd4,
        ST_KEYGEN = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    localparam logic [1:0] KEY_LEN_128  = 2'b00;
    localparam logic [1:0] KEY_LEN_192  = 2'b01;
    localparam logic [1:0] KEY_LEN_256  = 2'b10;
    localparam logic [1:0] KEY_LEN_RSVD = 2'b11;

    localparam int unsigned NR_128 = 10;
    localparam int unsigned NR_192 = 12;
    localparam int unsigned NR_256 = 14;

    // Reserved length never gets latched, so its return value is irrelevant.
    function automatic int unsigned nr_for_len(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_192: nr_for_len = NR_192;
            KEY_LEN_256: nr_for_len = NR_256;
            default:     nr_for_len = NR_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_stage_wdog.sv
// Per-state cycle watchdog: counts cycles spent in the current stage state.
// o_expire is combinational and high on the TIMEOUT-th cycle in the same state.
module aes_stage_wdog
    import aes_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_active,
    input  logic i_restart,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // Count 0 on the first cycle of a state, so count TIMEOUT-1 marks the TIMEOUT-th cycle.
    always_ff @(posedge clk) begin
        if (reset || i_restart || !i_active) begin
            r_cnt <= '0;
        end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_active && (r_cnt == LAST);

endmodule

// File: rtl/aes_round_seq.sv
// AES round sequencer: walks ADD/SUB/SHIFT/MIX/KEYGEN per round, registered level requests, one cycle per stage when strobes are ready.
// Optional per-stage watchdog under AES_ROUND_SEQ_WDOG_EN; otherwise stages wait indefinitely for their strobe.
module aes_round_seq
    import aes_ctrl_pkg::*;
#(
    parameter int CNT_W         = 4,
    parameter int STAGE_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [1:0]       i_key_len,
    input  logic             i_abort,
    input  logic             i_add_done,
    input  logic             i_sub_done,
    input  logic             i_shift_done,
    input  logic             i_mix_done,
    input  logic             i_key_ready,
    output logic             o_add_req,
    output logic             o_sub_req,
    output logic             o_shift_req,
    output logic             o_mix_req,
    output logic             o_key_req,
    output logic [CNT_W-1:0] o_round,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error
);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_key_len;
    logic [CNT_W-1:0] r_round;
    logic [CNT_W-1:0] w_round_nx;
    logic [CNT_W-1:0] w_nr;
    logic             w_accept;
    logic             w_error_nx;
    logic             r_add_req, r_sub_req, r_shift_req, r_mix_req, r_key_req;
    logic             r_busy, r_done, r_error;

    assign w_nr = CNT_W'(nr_for_len(r_key_len));

`ifdef AES_ROUND_SEQ_WDOG_EN
    logic w_wdog_expire;
    logic w_stage_active;

    assign w_stage_active = (r_state == ST_ADD) || (r_state == ST_SUB) ||
                            (r_state == ST_SHIFT) || (r_state == ST_MIX) ||
                            (r_state == ST_KEYGEN);

    aes_stage_wdog #(
        .TIMEOUT (STAGE_TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .reset     (reset),
        .i_active  (w_stage_active),
        .i_restart (w_next != r_state),
        .o_expire  (w_wdog_expire)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (STAGE_TIMEOUT > 0);
`endif

    // Requests mirror the state register, so gating strobes on them ignores strobes from other stages.
    always_comb begin
        w_next     = r_state;
        w_round_nx = r_round;
        w_accept   = 1'b0;
        w_error_nx = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_key_len == KEY_LEN_RSVD) begin
                        w_error_nx = 1'b1;
                    end else begin
                        w_next     = ST_ADD;
                        w_round_nx = '0;
                        w_accept   = 1'b1;
                    end
                end
            end
            ST_ADD: begin
                if (r_add_req && i_add_done) begin
                    if (r_round == w_nr) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next     = ST_SUB;
                        w_round_nx = r_round + 1'b1;
                    end
                end
            end
            ST_SUB: begin
                if (r_sub_req && i_sub_done) w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Final round skips MixColumns.
                if (r_shift_req && i_shift_done) w_next = (r_round < w_nr) ? ST_MIX : ST_KEYGEN;
            end
            ST_MIX: begin
                if (r_mix_req && i_mix_done) w_next = ST_KEYGEN;
            end
            ST_KEYGEN: begin
                if (r_key_req && i_key_ready) w_next = ST_ADD;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase

`ifdef AES_ROUND_SEQ_WDOG_EN
        // A strobe arriving on the expiry cycle still wins.
        if (w_wdog_expire && (w_next == r_state)) begin
            w_next     = ST_IDLE;
            w_error_nx = 1'b1;
        end
`endif

        if (i_abort) begin
            w_next     = ST_IDLE;
            w_round_nx = r_round;
            w_accept   = 1'b0;
            w_error_nx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_round     <= '0;
            r_key_len   <= KEY_LEN_128;
            r_add_req   <= 1'b0;
            r_sub_req   <= 1'b0;
            r_shift_req <= 1'b0;
            r_mix_req   <= 1'b0;
            r_key_req   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_round     <= w_round_nx;
            r_add_req   <= (w_next == ST_ADD);
            r_sub_req   <= (w_next == ST_SUB);
            r_shift_req <= (w_next == ST_SHIFT);
            r_mix_req   <= (w_next == ST_MIX);
            r_key_req   <= (w_next == ST_KEYGEN);
            r_busy      <= (w_next != ST_IDLE);
            r_done      <= (w_next == ST_DONE);
            r_error     <= w_error_nx;
            if (w_accept) r_key_len <= i_key_len;
        end
    end

    assign o_add_req   = r_add_req;
    assign o_sub_req   = r_sub_req;
    assign o_shift_req = r_shift_req;
    assign o_mix_req   = r_mix_req;
    assign o_key_req   = r_key_req;
    assign o_round     = r_round;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;

endmodule

// File: tb/tb_aes_round_seq.sv
// Bench for aes_round_seq: directed timing runs, randomized strobes against a visit-list model, abort/reset/watchdog cases.
module tb_aes_round_seq;

    localparam int CNT_W = 4;
    localparam int TO    = 8;

    localparam int C_ADD   = 1;
    localparam int C_SUB   = 2;
    localparam int C_SHIFT = 3;
    localparam int C_MIX   = 4;
    localparam int C_KEY   = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             i_start;
    logic [1:0]       i_key_len;
    logic             i_abort;
    logic             i_add_done, i_sub_done, i_shift_done, i_mix_done, i_key_ready;
    logic             o_add_req, o_sub_req, o_shift_req, o_mix_req, o_key_req;
    logic [CNT_W-1:0] o_round;
    logic             o_busy, o_done, o_error;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int obs_q[$];

    aes_round_seq #(
        .CNT_W         (CNT_W),
        .STAGE_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_key_len    (i_key_len),
        .i_abort      (i_abort),
        .i_add_done   (i_add_done),
        .i_sub_done   (i_sub_done),
        .i_shift_done (i_shift_done),
        .i_mix_done   (i_mix_done),
        .i_key_ready  (i_key_ready),
        .o_add_req    (o_add_req),
        .o_sub_req    (o_sub_req),
        .o_shift_req  (o_shift_req),
        .o_mix_req    (o_mix_req),
        .o_key_req    (o_key_req),
        .o_round      (o_round),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int nr_of(input logic [1:0] len);
        case (len)
            2'b01:   return 12;
            2'b10:   return 14;
            default: return 10;
        endcase
    endfunction

    // Expected stage visits as stage*16+round, derived from the round structure of AES.
    task automatic build_exp(input int nr);
        exp_q.delete();
        exp_q.push_back(C_ADD * 16);
        for (int r = 1; r <= nr; r++) begin
            exp_q.push_back(C_SUB * 16 + r);
            exp_q.push_back(C_SHIFT * 16 + r);
            if (r < nr) exp_q.push_back(C_MIX * 16 + r);
            exp_q.push_back(C_KEY * 16 + r);
            exp_q.push_back(C_ADD * 16 + r);
        end
    endtask

    function automatic int count_stage(input int code);
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i] / 16 == code) n++;
        return n;
    endfunction

    function automatic int req_code();
        int n = int'(o_add_req) + int'(o_sub_req) + int'(o_shift_req) + int'(o_mix_req) + int'(o_key_req);
        if (n == 0) return 0;
        if (n > 1)  return 9;
        if (o_add_req)   return C_ADD;
        if (o_sub_req)   return C_SUB;
        if (o_shift_req) return C_SHIFT;
        if (o_mix_req)   return C_MIX;
        return C_KEY;
    endfunction

    task automatic set_strobes(input logic v);
        i_add_done = v; i_sub_done = v; i_shift_done = v; i_mix_done = v; i_key_ready = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_directed(input logic [1:0] len, input string tag);
        int nr, cnt, mix, key, key_r0;
        logic seen, prev_mix, prev_key;
        nr = nr_of(len);
        build_exp(nr);
        set_strobes(1'b1);
        i_key_len = len;
        i_start   = 1'b1;
        step();
        i_start = 1'b0;
        cnt = 0; mix = 0; key = 0; key_r0 = 0; seen = 1'b0; prev_mix = 1'b0; prev_key = 1'b0;
        for (int c = 0; c < 200; c++) begin
            cnt++;
            if (o_mix_req && !prev_mix) mix++;
            if (o_key_req && !prev_key) key++;
            if (o_key_req && o_round == 0) key_r0++;
            prev_mix = o_mix_req;
            prev_key = o_key_req;
            if (o_done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
        check_val({tag, "_latency"}, 32'(cnt), 32'(exp_q.size() + 1));
        check_val({tag, "_round"}, 32'(o_round), 32'(nr));
        check_val({tag, "_mix_pulses"}, 32'(mix), 32'(count_stage(C_MIX)));
        check_val({tag, "_key_pulses"}, 32'(key), 32'(count_stage(C_KEY)));
        check_val({tag, "_key_r0"}, 32'(key_r0), 32'd0);
        step();
        check_val({tag, "_done_1cyc"}, 32'(o_done), 32'd0);
        check_val({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
        check_val({tag, "_round_hold"}, 32'(o_round), 32'(nr));
        set_strobes(1'b0);
    endtask

    task automatic run_random(input logic [1:0] len, input string tag);
        int nr, prev, code, nbad;
        logic seen, multi, dropped;
        nr = nr_of(len);
        build_exp(nr);
        obs_q.delete();
        i_key_len = len;
        i_start   = 1'b1;
        step();
        prev = 0; seen = 1'b0; multi = 1'b0; dropped = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            code = req_code();
            if (code == 9) multi = 1'b1;
            if (!o_busy) dropped = 1'b1;
            if (code != 0 && code != prev) obs_q.push_back(code * 16 + int'(o_round));
            prev = code;
            if (o_done) begin
                seen = 1'b1;
                break;
            end
            // Random starts and key lengths mid-run must be ignored.
            i_add_done   = ($urandom_range(0, 3) != 0);
            i_sub_done   = ($urandom_range(0, 3) != 0);
            i_shift_done = ($urandom_range(0, 3) != 0);
            i_mix_done   = ($urandom_range(0, 3) != 0);
            i_key_ready  = ($urandom_range(0, 3) != 0);
            i_start      = ($urandom_range(0, 3) == 0);
            i_key_len    = 2'($urandom_range(0, 3));
            step();
        end
        i_start = 1'b0;
        set_strobes(1'b0);
        nbad = 0;
        if (obs_q.size() != exp_q.size()) nbad = 1000;
        else foreach (exp_q[i]) if (obs_q[i] != exp_q[i]) nbad++;
        check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
        check_val({tag, "_visit_mismatches"}, 32'(nbad), 32'd0);
        check_val({tag, "_onehot_viol"}, 32'(multi), 32'd0);
        check_val({tag, "_busy_drop"}, 32'(dropped), 32'd0);
        check_val({tag, "_round"}, 32'(o_round), 32'(nr));
        step();
    endtask

    initial begin
        int errs, busys, reqs, subs;
        logic found, done_seen;
        reset = 1'b1; i_start = 1'b0; i_key_len = 2'b00; i_abort = 1'b0;
        set_strobes(1'b0);
        repeat (3) step();
        check_val("rst_round", 32'(o_round), 32'd0);
        check_val("rst_busy", 32'(o_busy), 32'd0);
        check_val("rst_reqs", 32'(req_code()), 32'd0);
        check_val("rst_done", 32'(o_done), 32'd0);
        check_val("rst_error", 32'(o_error), 32'd0);
        reset = 1'b0;
        step();

        run_directed(2'b00, "k128");
        run_directed(2'b01, "k192");
        run_directed(2'b10, "k256");

        // Reserved key length.
        i_key_len = 2'b11; i_start = 1'b1;
        step();
        i_start = 1'b0;
        errs = 0; busys = 0; reqs = 0;
        for (int c = 0; c < 6; c++) begin
            if (o_error) errs++;
            if (o_busy) busys++;
            if (req_code() != 0) reqs++;
            step();
        end
        check_val("rsvd_error_pulses", 32'(errs), 32'd1);
        check_val("rsvd_busy_cycles", 32'(busys), 32'd0);
        check_val("rsvd_req_cycles", 32'(reqs), 32'd0);

        // Abort in round 5 SHIFT.
        set_strobes(1'b1);
        i_key_len = 2'b00; i_start = 1'b1;
        step();
        i_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (o_shift_req && o_round == 5) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check_val("abort_reach_r5_shift", 32'(found), 32'd1);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check_val("abort_busy", 32'(o_busy), 32'd0);
        check_val("abort_reqs", 32'(req_code()), 32'd0);
        done_seen = 1'b0; errs = 0;
        for (int c = 0; c < 60; c++) begin
            if (o_done) done_seen = 1'b1;
            if (o_error) errs++;
            step();
        end
        check_val("abort_no_done", 32'(done_seen), 32'd0);
        check_val("abort_no_error", 32'(errs), 32'd0);
        set_strobes(1'b0);
        run_directed(2'b00, "post_abort");

        // Abort beats start, including a reserved-length start.
        i_start = 1'b1; i_abort = 1'b1; i_key_len = 2'b00;
        step();
        check_val("abort_vs_start_busy", 32'(o_busy), 32'd0);
        i_key_len = 2'b11;
        step();
        check_val("abort_vs_rsvd_error", 32'(o_error), 32'd0);
        i_start = 1'b0; i_abort = 1'b0;
        step();

        run_random(2'b00, "rnd128");
        run_random(2'b01, "rnd192");
        run_random(2'b10, "rnd256");
        run_random(2'($urandom_range(0, 2)), "rndany");

        // Reset mid-operation beats abort and strobes.
        set_strobes(1'b1);
        i_key_len = 2'b10; i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (20) step();
        reset = 1'b1; i_abort = 1'b1;
        step();
        check_val("midrst_round", 32'(o_round), 32'd0);
        check_val("midrst_busy", 32'(o_busy), 32'd0);
        check_val("midrst_reqs", 32'(req_code()), 32'd0);
        check_val("midrst_done_err", 32'({o_done, o_error}), 32'd0);
        reset = 1'b0; i_abort = 1'b0;
        set_strobes(1'b0);
        step();

        // Stuck SubBytes stage.
        i_add_done = 1'b1;
        i_key_len = 2'b00; i_start = 1'b1;
        step();
        i_start = 1'b0;
        subs = 0; errs = 0;
        for (int c = 0; c < 40; c++) begin
            if (o_sub_req) subs++;
            if (o_error) errs++;
            step();
        end
`ifdef AES_ROUND_SEQ_WDOG_EN
        check_val("wdog_sub_cycles", 32'(subs), 32'(TO));
        check_val("wdog_error_pulses", 32'(errs), 32'd1);
        check_val("wdog_idle", 32'(o_busy), 32'd0);
`else
        check_val("nowdog_still_sub", 32'(o_sub_req), 32'd1);
        check_val("nowdog_error_pulses", 32'(errs), 32'd0);
        check_val("nowdog_busy", 32'(o_busy), 32'd1);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check_val("nowdog_abort_idle", 32'(o_busy), 32'd0);
`endif
        set_strobes(1'b0);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
